// File: rtl/irq_pkg.sv
// Shared types and helpers for the irq_pri_ctrl block.
package irq_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned TW   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PRES = 1'b1
    } state_e;

    // Expand a 2-bit line index into its 4-bit one-hot mask.
    function automatic logic [NREQ-1:0] onehot4(input logic [CW-1:0] c);
        logic [NREQ-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_pri_ctrl_pri_enc4.sv
// 4->2 priority encoder, bit 3 has highest priority.
module pri_enc4
    import irq_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    output logic [CW-1:0]   code_o,
    output logic            any_o
);

    // Highest set bit wins; code is 0 when nothing is set.
    always_comb begin
        code_o = 2'd0;
        any_o  = |req_i;
        if (req_i[3])      code_o = 2'd3;
        else if (req_i[2]) code_o = 2'd2;
        else if (req_i[1]) code_o = 2'd1;
        else               code_o = 2'd0;
    end

endmodule

// File: rtl/irq_pri_ctrl.sv
// Interrupt front end: edge capture, priority encode, valid/ack presentation
// with timeout. Optional feature macro: IRQ_MASK_EN (adds the mask port).
module irq_pri_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
`ifdef IRQ_MASK_EN
    input  logic [NREQ-1:0] mask,
`endif
    output logic            valid,
    output logic [CW-1:0]   code,
    output logic [NREQ-1:0] pend,
    output logic            tmo
);

    state_e          state_q;
    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] pend_q;
    logic [NREQ-1:0] pend_d;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] clr;
    logic [CW-1:0]   code_q;
    logic [CW-1:0]   enc_code;
    logic            enc_any;
    logic            valid_q;
    logic            tmo_q;
    logic [TW-1:0]   timer_q;

    // Masked lines stay pending but do not take part in arbitration.
    always_comb begin
`ifdef IRQ_MASK_EN
        eligible = pend_q & ~mask;
`else
        eligible = pend_q;
`endif
    end

    pri_enc4 u_enc (
        .req_i  (eligible),
        .code_o (enc_code),
        .any_o  (enc_any)
    );

    // Next pending value: clear served line on ack, new rising edges win over the clear.
    always_comb begin
        clr    = '0;
        pend_d = pend_q;
        if (state_q == PRES && en && ack) begin
            clr = onehot4(code_q);
        end
        if (en) begin
            pend_d = (pend_q & ~clr) | (req & ~req_q);
        end
    end

    // Capture registers, presentation FSM and timeout timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
            tmo_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && enc_any) begin
                        code_q  <= enc_code;
                        valid_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= PRES;
                    end
                end
                PRES: begin
                    if (!en || ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_q == TW'(TMO_CYC - 1)) begin
                        valid_q <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign valid = valid_q;
    assign code  = code_q;
    assign pend  = pend_q;
    assign tmo   = tmo_q;

endmodule

// File: tb/tb_irq_pri_ctrl.sv
// Self-checking bench for irq_pri_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_irq_pri_ctrl;

    localparam int unsigned TMO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       ack;
`ifdef IRQ_MASK_EN
    logic [3:0] mask;
`endif
    logic       valid;
    logic [1:0] code;
    logic [3:0] pend;
    logic       tmo;

    always #5 clk = ~clk;

    irq_pri_ctrl #(.TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .ack   (ack),
`ifdef IRQ_MASK_EN
        .mask  (mask),
`endif
        .valid (valid),
        .code  (code),
        .pend  (pend),
        .tmo   (tmo)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: set of pending lines plus "which line is on offer, for how long".
    bit [3:0] m_pend;
    bit [3:0] m_prev;
    bit       m_pres;
    int       m_cur;
    int       m_age;
    bit       m_tmo;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic       ack;
        logic       v;
        logic [1:0] c;
        logic [3:0] p;
        logic       t;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [3:0] mk;
        bit [3:0] elig;
        bit [3:0] edges;
        bit [3:0] served;
`ifdef IRQ_MASK_EN
        mk = mask;
`else
        mk = 4'h0;
`endif
        if (rst) begin
            m_pend = 0; m_prev = 0; m_pres = 0; m_cur = 0; m_age = 0; m_tmo = 0;
        end else begin
            elig   = m_pend & ~mk;
            edges  = req & ~m_prev;
            served = 4'h0;
            m_prev = req;
            m_tmo  = 0;
            if (m_pres) begin
                if (!en) m_pres = 0;
                else if (ack) begin
                    served[m_cur] = 1'b1;
                    m_pres = 0;
                end else if (m_age + 1 == int'(TMO)) begin
                    m_pres = 0;
                    m_tmo  = 1;
                end else m_age++;
            end else if (en && elig != 0) begin
                for (int i = 0; i < 4; i++) if (elig[i]) m_cur = i;
                m_pres = 1;
                m_age  = 0;
            end
            if (en) m_pend = (m_pend & ~served) | edges;
        end
    endtask

    // Apply inputs, clock one edge, advance the model, settle at the falling edge.
    task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic a);
        rst = r; en = e; req = rq; ack = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, int'(valid), int'(m_pres));
        chk({tag, "_code"},  int'(code),  m_cur);
        chk({tag, "_pend"},  int'(pend),  int'(m_pend));
        chk({tag, "_tmo"},   int'(tmo),   int'(m_tmo));
    endtask

    initial begin
        int cnt;
        logic r;
        logic e;
        logic a;
        logic [3:0] rq;

        rst = 1'b1; en = 1'b0; req = 4'h0; ack = 1'b0;
`ifdef IRQ_MASK_EN
        mask = 4'h0;
`endif
        @(negedge clk);

        // Reset, single request and priority ordering as a cycle table.
        tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 2'd0, 4'h4, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 2'd2, 4'hB, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 2'd3, 4'hB, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 2'd3, 4'h3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 2'd1, 4'h3, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 2'd1, 4'h1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].ack);
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d_code", i),  int'(code),  int'(tbl[i].c));
            chk($sformatf("tbl%0d_pend", i),  int'(pend),  int'(tbl[i].p));
            chk($sformatf("tbl%0d_tmo", i),   int'(tmo),   int'(tbl[i].t));
        end

        // Timeout: line 1 is offered for TMO cycles, pulses tmo, then is re-offered.
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b0);
        chk("tmo_pend_set", int'(pend), 4'h2);
        step(1'b0, 1'b1, 4'h2, 1'b0);
        chk("tmo_first_valid", int'(valid), 1);
        chk("tmo_first_code", int'(code), 1);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 4'h2, 1'b0);
            if (valid) cnt++;
            else break;
        end
        chk("tmo_valid_cycles", cnt, int'(TMO));
        chk("tmo_pulse", int'(tmo), 1);
        chk("tmo_valid_low", int'(valid), 0);
        chk("tmo_pend_kept", int'(pend), 4'h2);
        step(1'b0, 1'b1, 4'h2, 1'b0);
        chk("tmo_pulse_end", int'(tmo), 0);
        chk("tmo_reoffer_valid", int'(valid), 1);
        chk("tmo_reoffer_code", int'(code), 1);
        step(1'b0, 1'b1, 4'h2, 1'b1);
        chk("tmo_ack_clear", int'(pend), 4'h0);

        // Ack and a new edge on the same line at the same edge: set wins.
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h4, 1'b0);
        step(1'b0, 1'b1, 4'h4, 1'b0);
        chk("sim_offer_code", int'(code), 2);
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h4, 1'b1);
        chk("sim_set_wins_pend", int'(pend), 4'h4);
        chk("sim_set_wins_valid", int'(valid), 0);
        step(1'b0, 1'b1, 4'h4, 1'b0);
        chk("sim_reoffer_valid", int'(valid), 1);
        chk("sim_reoffer_code", int'(code), 2);
        // Ack lands on the edge that would have timed out.
        for (int i = 0; i < int'(TMO) - 1; i++) step(1'b0, 1'b1, 4'h4, 1'b0);
        chk("acktmo_still_valid", int'(valid), 1);
        step(1'b0, 1'b1, 4'h4, 1'b1);
        chk("acktmo_no_tmo", int'(tmo), 0);
        chk("acktmo_valid", int'(valid), 0);
        chk("acktmo_pend", int'(pend), 4'h0);
        step(1'b0, 1'b1, 4'h4, 1'b0);
        chk("acktmo_no_tmo_late", int'(tmo), 0);

        // Edges while disabled are lost.
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h1, 1'b0);
        chk("en0_pend", int'(pend), 4'h0);
        chk("en0_valid", int'(valid), 0);
        step(1'b0, 1'b1, 4'h1, 1'b0);
        chk("en1_no_late_edge", int'(pend), 4'h0);
        chk("en1_valid", int'(valid), 0);

`ifdef IRQ_MASK_EN
        // Masked line stays pending but loses arbitration until unmasked.
        mask = 4'h8;
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        chk("mask_pend", int'(pend), 4'h9);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        chk("mask_code", int'(code), 0);
        mask = 4'h0;
        step(1'b0, 1'b1, 4'h9, 1'b1);
        chk("mask_ack_pend", int'(pend), 4'h8);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        chk("unmask_code", int'(code), 3);
        step(1'b0, 1'b1, 4'h9, 1'b1);
`endif

        // Randomized traffic against the model.
        step(1'b1, 1'b1, 4'h0, 1'b0);
        check_model("rnd_reset");
        rq = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            a  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) rq = 4'($urandom);
`ifdef IRQ_MASK_EN
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
`endif
            step(r, e, rq, a);
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
